// File: rtl/prog_loader.sv
// Program loader: parses a framed byte stream (sync, base, count, words, checksum),
// writes big-endian words into core memory and releases the core on a good frame.
module prog_loader #(
  parameter int ADDR_W    = 10,
  parameter int MEM_DEPTH = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              core_start,
  output logic [ADDR_W-1:0] start_pc,
  output logic              load_done,
  output logic              load_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_DATA_HI, S_DATA_LO, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t              r_state, w_state_n;
  logic                r_in_ready;
  logic [1:0]          r_hidx;
  logic [15:0]         r_base;
  logic [7:0]          r_cnt_hi;
  logic [15:0]         r_cnt;
  logic [15:0]         r_widx;
  logic [7:0]          r_hi;
  logic [7:0]          r_sum;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [15:0]         r_mem_wdata;

  logic                w_acc, w_sync, w_hdr_ok;
  logic [15:0]         w_cnt;
  logic [16:0]         w_end;

  assign w_acc    = in_valid & r_in_ready;
  assign w_sync   = (in_data == 8'hA5);
  assign w_cnt    = {r_cnt_hi, in_data};
  // 17-bit sum so a huge base+count cannot wrap back into range
  assign w_end    = {1'b0, r_base} + {1'b0, w_cnt};
  assign w_hdr_ok = ((r_base >> ADDR_W) == 16'd0) && (w_end <= 17'(MEM_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    if (w_acc) begin
      case (r_state)
        S_IDLE:    if (w_sync) w_state_n = S_HDR;
        S_HDR:
          if (r_hidx == 2'd3) begin
            if (!w_hdr_ok)          w_state_n = S_ERR;
            else if (w_cnt == 16'd0) w_state_n = S_CHK;
            else                    w_state_n = S_DATA_HI;
          end
        S_DATA_HI: w_state_n = S_DATA_LO;
        S_DATA_LO: w_state_n = (r_widx + 16'd1 == r_cnt) ? S_CHK : S_DATA_HI;
        S_CHK:     w_state_n = (in_data == r_sum) ? S_DONE : S_ERR;
        S_ERR:     if (w_sync) w_state_n = S_HDR;
        default:   w_state_n = r_state;
      endcase
    end
  end

  always_comb begin
    load_done  = (r_state == S_DONE);
    core_start = (r_state == S_DONE);
    start_pc   = (r_state == S_DONE) ? r_base[ADDR_W-1:0] : '0;
    load_err   = (r_state == S_ERR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready  <= 1'b0;
      r_hidx      <= '0;
      r_base      <= '0;
      r_cnt_hi    <= '0;
      r_cnt       <= '0;
      r_widx      <= '0;
      r_hi        <= '0;
      r_sum       <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_in_ready <= (w_state_n != S_DONE);
      r_mem_we   <= 1'b0;
      if (w_acc) begin
        case (r_state)
          S_IDLE, S_ERR:
            if (w_sync) begin
              r_sum  <= '0;
              r_hidx <= '0;
            end
          S_HDR: begin
            r_sum  <= r_sum + in_data;
            r_hidx <= r_hidx + 2'd1;
            case (r_hidx)
              2'd0: r_base[15:8] <= in_data;
              2'd1: r_base[7:0]  <= in_data;
              2'd2: r_cnt_hi     <= in_data;
              default: begin
                r_cnt  <= w_cnt;
                r_widx <= '0;
              end
            endcase
          end
          S_DATA_HI: begin
            r_sum <= r_sum + in_data;
            r_hi  <= in_data;
          end
          S_DATA_LO: begin
            r_sum       <= r_sum + in_data;
            r_mem_we    <= 1'b1;
            r_mem_wdata <= {r_hi, in_data};
            r_mem_addr  <= r_base[ADDR_W-1:0] + r_widx[ADDR_W-1:0];
            r_widx      <= r_widx + 16'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: table of frames, hand-written corner sequences and random
// frames, all judged against expectations derived from the frame contents.
module tb_prog_loader;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, mem_we, core_start, load_done, load_err;
  logic [9:0]  mem_addr, start_pc;
  logic [15:0] mem_wdata;

  prog_loader #(.ADDR_W(10), .MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .core_start(core_start), .start_pc(start_pc),
    .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, gap_pct = 0;
  logic [9:0]  wq_addr[$];
  logic [15:0] wq_data[$];
  logic [15:0] wd[$];

  always @(negedge clk)
    if (rst_n && mem_we) begin
      wq_addr.push_back(mem_addr);
      wq_data.push_back(mem_wdata);
    end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Called just after a negedge; returns just after the negedge following acceptance.
  task automatic send_byte(input logic [7:0] b);
    int waitc = 0;
    logic rdy;
    while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    forever begin
      rdy = in_ready;
      @(posedge clk);
      if (rdy) break;
      waitc++;
      if (waitc > 50) begin
        total++; bad++;
        $display("FAIL accept_timeout: byte %0h not accepted within 50 cycles", b);
        break;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_in_ready"}, in_ready, 0);
    chk({nm, "_mem_we"}, mem_we, 0);
    chk({nm, "_mem_addr"}, mem_addr, 0);
    chk({nm, "_mem_wdata"}, mem_wdata, 0);
    chk({nm, "_core_start"}, core_start, 0);
    chk({nm, "_start_pc"}, start_pc, 0);
    chk({nm, "_load_done"}, load_done, 0);
    chk({nm, "_load_err"}, load_err, 0);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_data  = 8'h00;
    rst_n    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", in_ready, 1);
    wq_addr.delete();
    wq_data.delete();
  endtask

  // Reference: a frame is legal when the whole word range fits in memory; checksum is
  // the byte sum after sync. Good frames end DONE, everything else ends in ERR.
  task automatic run_frame(input logic [15:0] base, input logic [15:0] cnt,
                           input bit bad_chk, input int gap, input string nm,
                           output bit done_o, output int nwr_o);
    logic [7:0] bytes[$];
    logic [7:0] s;
    bit ok, exp_done;
    int n;
    ok = (int'(base) < DEPTH) && (int'(base) + int'(cnt) <= DEPTH);
    bytes = {8'hA5, base[15:8], base[7:0], cnt[15:8], cnt[7:0]};
    if (ok) begin
      for (int i = 0; i < int'(cnt); i++) begin
        bytes.push_back(wd[i][15:8]);
        bytes.push_back(wd[i][7:0]);
      end
      s = 8'h00;
      for (int i = 1; i < bytes.size(); i++) s = s + bytes[i];
      bytes.push_back(bad_chk ? s + 8'd1 : s);
    end
    wq_addr.delete();
    wq_data.delete();
    gap_pct = gap;
    foreach (bytes[i]) send_byte(bytes[i]);
    gap_pct = 0;
    exp_done = ok && !bad_chk;
    n = ok ? int'(cnt) : 0;
    chk({nm, "_load_done"}, load_done, exp_done);
    chk({nm, "_core_start"}, core_start, exp_done);
    chk({nm, "_load_err"}, load_err, !exp_done);
    chk({nm, "_start_pc"}, start_pc, exp_done ? base[9:0] : 10'd0);
    chk({nm, "_in_ready"}, in_ready, !exp_done);
    chk({nm, "_nwrites"}, wq_addr.size(), n);
    for (int i = 0; i < n && i < wq_addr.size(); i++) begin
      chk({nm, "_waddr"}, wq_addr[i], 32'(base) + 32'(i));
      chk({nm, "_wdata"}, wq_data[i], wd[i]);
    end
    done_o = exp_done;
    nwr_o  = wq_addr.size();
  endtask

  typedef struct {
    logic [15:0] base;
    logic [15:0] cnt;
    bit          bad_chk;
    int          gap;
    bit          exp_done;
    int          exp_writes;
  } vec_t;

  initial begin
    vec_t tbl[$];
    logic [7:0] lit[$];
    bit d;
    int nw;

    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    #1 chk_reset_vals("rst");
    do_reset();

    // literal single-word frame with exact latency checks
    lit = {8'hA5, 8'h00, 8'h00, 8'h00, 8'h01, 8'h78, 8'h88};
    foreach (lit[i]) send_byte(lit[i]);
    chk("lit_we", mem_we, 1);
    chk("lit_addr", mem_addr, 0);
    chk("lit_data", mem_wdata, 16'h7888);
    send_byte(8'h01);
    chk("lit_we_drop", mem_we, 0);
    chk("lit_done", load_done, 1);
    chk("lit_start", core_start, 1);
    chk("lit_pc", start_pc, 0);
    chk("lit_ready", in_ready, 0);
    chk("lit_nwr", wq_addr.size(), 1);

    // bad checksum, then recovery on the next sync
    do_reset();
    lit = {8'hA5, 8'h00, 8'h00, 8'h00, 8'h01, 8'h78, 8'h88, 8'h02};
    foreach (lit[i]) send_byte(lit[i]);
    chk("bchk_err", load_err, 1);
    chk("bchk_start", core_start, 0);
    chk("bchk_nwr", wq_addr.size(), 1);
    chk("bchk_ready", in_ready, 1);
    send_byte(8'h33);
    chk("err_noise_hold", load_err, 1);
    send_byte(8'hA5);
    chk("err_clear_on_sync", load_err, 0);
    lit = {8'h00, 8'h05, 8'h00, 8'h01, 8'hBE, 8'hEF};
    foreach (lit[i]) send_byte(lit[i]);
    send_byte(8'(8'h05 + 8'h01 + 8'hBE + 8'hEF));
    chk("recov_done", load_done, 1);
    chk("recov_pc", start_pc, 10'd5);

    // noise then an empty frame
    do_reset();
    lit = {8'h00, 8'hFF, 8'h13, 8'hA5, 8'h00, 8'h10, 8'h00, 8'h00, 8'h10};
    foreach (lit[i]) send_byte(lit[i]);
    chk("empty_done", load_done, 1);
    chk("empty_pc", start_pc, 10'd16);
    chk("empty_nwr", wq_addr.size(), 0);

    // async reset between hi and lo of the third word
    do_reset();
    lit = {8'hA5, 8'h00, 8'h00, 8'h00, 8'h03, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33};
    foreach (lit[i]) send_byte(lit[i]);
    rst_n = 1'b0;
    #1 chk_reset_vals("midrst");
    repeat (2) @(negedge clk);
    chk("midrst_nwr", wq_addr.size(), 2);
    do_reset();
    wd = {16'h1111, 16'h2222, 16'h3333};
    run_frame(16'h0000, 16'd3, 0, 0, "reload", d, nw);

    // table-driven frames
    tbl.push_back('{16'h03FC, 16'd4,     0, 0,  1, 4});
    tbl.push_back('{16'h03FC, 16'd5,     0, 0,  0, 0});
    tbl.push_back('{16'h0400, 16'd1,     0, 0,  0, 0});
    tbl.push_back('{16'h0000, 16'd9,     0, 40, 1, 9});
    tbl.push_back('{16'h0010, 16'd0,     0, 0,  1, 0});
    tbl.push_back('{16'h0000, 16'd1,     1, 0,  0, 1});
    tbl.push_back('{16'h03FF, 16'd1,     0, 30, 1, 1});
    tbl.push_back('{16'h0200, 16'h0201,  0, 0,  0, 0});
    tbl.push_back('{16'hFC00, 16'h0400,  0, 0,  0, 0});
    foreach (tbl[t]) begin
      do_reset();
      wd.delete();
      for (int i = 0; i < 16; i++) wd.push_back(16'($urandom));
      run_frame(tbl[t].base, tbl[t].cnt, tbl[t].bad_chk, tbl[t].gap, $sformatf("tbl%0d", t), d, nw);
      chk($sformatf("tbl%0d_exp_done", t), d, tbl[t].exp_done);
      chk($sformatf("tbl%0d_exp_wr", t), nw, tbl[t].exp_writes);
    end

    // random frames
    for (int r = 0; r < 24; r++) begin
      logic [15:0] b, c;
      do_reset();
      c = 16'($urandom_range(0, 12));
      b = ($urandom_range(4) == 0) ? 16'($urandom_range(1005, 1100)) : 16'($urandom_range(0, 1011));
      wd.delete();
      for (int i = 0; i < int'(c); i++) wd.push_back(16'($urandom));
      run_frame(b, c, ($urandom_range(3) == 0), $urandom_range(0, 50), $sformatf("rnd%0d", r), d, nw);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Upstream program loader for the 16-bit RISC core. It receives a framed byte stream over a valid/ready handshake and assembles big-endian 16-bit words. It writes those words into the core's 1024×16 unified memory through a dedicated write port. After a frame passes its checksum, it asserts `core_start` with the load base address, which releases the core to fetch from that address.

## Interface
- `ADDR_W`, default 10, memory address width.
- `MEM_DEPTH`, default 1024, number of 16-bit words in core memory.

- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  byte on `in_data` is valid.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `mem_we`  out  1  one-cycle memory write strobe.
- `mem_addr`  out  ADDR_W  write address.
- `mem_wdata`  out  16  write data.
- `core_start`  out  1  level; core may begin fetching.
- `start_pc`  out  ADDR_W  initial PC for the core (the frame's base address).
- `load_done`  out  1  frame accepted, checksum good.
- `load_err`  out  1  frame rejected.

## Operation
- Byte transfer: a byte is accepted on a rising edge where `in_valid && in_ready`. Nothing else advances the FSM.
- Frame layout: sync `0xA5`, BASE_HI, BASE_LO, CNT_HI, CNT_LO, then CNT words sent hi byte then lo byte, then CHK.
- Checksum: CHK = 8-bit wrap-around sum of every byte after sync, excluding CHK itself. The running sum clears on sync acceptance.
- FSM states: IDLE, HDR, DATA_HI, DATA_LO, CHK, DONE, ERR.
- IDLE: non-`0xA5` bytes are accepted and dropped. `0xA5` moves to HDR with the header byte index at 0.
- HDR: accepts 4 bytes. On the 4th byte the FSM checks the header:
  - BASE must satisfy BASE[15:ADDR_W]==0, and BASE+CNT ≤ MEM_DEPTH, computed at 17 bits.
  - If either check fails, go to ERR.
  - If CNT==0, go to CHK.
  - Otherwise go to DATA_HI.
- DATA_HI: latches the high byte, then goes to DATA_LO.
- DATA_LO: on acceptance the word {hi,lo} is registered and the word index increments.
  - If index+1==CNT, go to CHK; otherwise go to DATA_HI.
- Write issue: one cycle after each DATA_LO acceptance, `mem_we`=1 for exactly one cycle, with `mem_addr`=BASE+index and `mem_wdata`={hi,lo}.
- CHK: accepts 1 byte.
  - If it matches the running sum, go to DONE.
  - Otherwise go to ERR. Memory already written is not rolled back.
- DONE: `in_ready`=0, `load_done`=1, `core_start`=1, `start_pc`=BASE. The FSM stays here until reset.
- ERR: `load_err`=1 and `in_ready`=1.
  - Non-sync bytes are dropped.
  - `0xA5` clears `load_err` on that edge and goes to HDR, starting a new frame.
- `in_ready` is registered: it is 1 in IDLE, HDR, DATA_HI, DATA_LO, CHK and ERR, and 0 in DONE.

## Timing
- Reset values:
  - `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `core_start`=0, `start_pc`=0, `load_done`=0, `load_err`=0.
  - FSM in IDLE, checksum 0, word index 0.
- After `rst_n` rises, `in_ready` goes to 1 on the first rising edge.
- With `in_valid` held high continuously, throughput is 1 byte per cycle (2 cycles per word). There are no loader-inserted stalls.
- Write latency: `mem_we` is high in the cycle after the edge that accepted the lo byte.
- The final word's write completes before `core_start` can rise, because CHK needs at least one more accepted byte.
- `load_done`, `core_start` and `start_pc` go valid in the cycle after CHK is accepted. `load_err` follows the same timing.
- A header error is flagged in the cycle after CNT_LO is accepted. No writes occur for that frame.
- Reset mid-frame: all state clears immediately and asynchronously, and `mem_we` drops in the same instant. Words written before reset remain in memory.
- `in_valid` low in any state: hold state. No timeout.
- `in_data` is ignored when `in_valid`=0.

## Test plan
- Single-word frame: send A5 00 00 00 01 78 88 01.
  - Expect one `mem_we` pulse, addr 0, data 0x7888.
  - Expect `load_done`=`core_start`=1 and `start_pc`=0 one cycle after the 8th byte.
- Back-pressure gaps: send a 9-word program at BASE=0 with random `in_valid` gaps.
  - Expect 9 writes to addresses 0..8 in order, each data word matching.
  - Expect `in_ready` to drop to 0 in DONE.
- Bad checksum: same frame as the first scenario with CHK=0x02.
  - Expect the write to addr 0 still occurs.
  - Expect `load_err`=1, `core_start`=0.
  - Then send a good frame and expect `load_err` to clear on its sync byte and `load_done`=1 at the end.
- Range boundary:
  - BASE=0x03FC, CNT=4: expect writes at 1020..1023 and success.
  - BASE=0x03FC, CNT=5: expect `load_err` after CNT_LO with zero writes.
  - BASE=0x0400, CNT=1: expect an error.
- Empty frame and noise: send 00 FF 13 then A5 00 10 00 00 10.
  - Expect the noise bytes dropped, no writes, and `load_done`=1 with `start_pc`=16.
- Async reset mid-data: assert `rst_n` low between the hi and lo bytes of word 2.
  - Expect all outputs at their reset values immediately and no `mem_we` for word 2.
  - Then send a full reload and expect success.
